// File: rtl/shifter_pkg.sv
// Shared constants and elaboration helpers for the pipelined log-shifter.
// Optional rotate support is selected with the SHIFTER_ROTATE_EN macro.
package shifter_pkg;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_ROR = 6'b000110;

`ifdef SHIFTER_ROTATE_EN
   localparam logic ROT_EN = 1'b1;
`else
   localparam logic ROT_EN = 1'b0;
`endif

   // Ceiling log2 for elaboration-time sizing.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 32'd1;
      end
      return r;
   endfunction

   // Number of log levels placed in a stage; leftover levels go to the earliest stages.
   function automatic int unsigned levels_in_stage(input int unsigned stage,
                                                   input int unsigned stages,
                                                   input int unsigned width);
      int unsigned lv;
      lv = clog2(width);
      return (lv / stages) + ((stage < (lv % stages)) ? 32'd1 : 32'd0);
   endfunction

   // Index of the first log level evaluated in a stage.
   function automatic int unsigned first_level(input int unsigned stage,
                                               input int unsigned stages,
                                               input int unsigned width);
      int unsigned r;
      r = 0;
      for (int unsigned s = 0; s < stage; s++) r = r + levels_in_stage(s, stages, width);
      return r;
   endfunction

   // Stage that owns a given log level.
   function automatic int unsigned stage_of_level(input int unsigned level,
                                                  input int unsigned stages,
                                                  input int unsigned width);
      int unsigned r;
      r = 0;
      for (int unsigned s = 0; s < stages; s++) begin
         if (level >= first_level(s, stages, width)) r = s;
      end
      return r;
   endfunction

   // Right-type ops run bit-reversed through the left-shift core.
   function automatic logic is_right(input logic [5:0] fn);
      return (fn == FN_SRL) || (fn == FN_SRA) || (ROT_EN && (fn == FN_ROR));
   endfunction

endpackage

// File: rtl/shifter_if.sv
// Operand/result handshake bundle between the EX-stage muxes and the shifter.
interface shifter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic [5:0]       Signal;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dataOut;

   modport master (
      output in_valid, dataA, dataB, Signal, out_ready,
      input  in_ready, out_valid, dataOut
   );

   modport slave (
      input  in_valid, dataA, dataB, Signal, out_ready,
      output in_ready, out_valid, dataOut
   );
endinterface

// File: rtl/shifter_level.sv
// One mux row of the left-shift core: shifts by SHIFT when enabled.
// With SHIFTER_ROTATE_EN the fill can be the wrapped-out bits.
module shifter_level #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHIFT = 1
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_en,
   input  logic             i_fill,
`ifdef SHIFTER_ROTATE_EN
   input  logic             i_rot,
`endif
   output logic [WIDTH-1:0] o_data_c
);
   logic [SHIFT-1:0] w_fill;

   // Fill source for the vacated low bits.
`ifdef SHIFTER_ROTATE_EN
   assign w_fill = i_rot ? i_data[WIDTH-1 -: SHIFT] : {SHIFT{i_fill}};
`else
   assign w_fill = {SHIFT{i_fill}};
`endif

   assign o_data_c = i_en ? {i_data[WIDTH-SHIFT-1:0], w_fill} : i_data;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined log-shifter (SLL/SRL/SRA, optional ROR) with valid/ready stalls.
// Define SHIFTER_ROTATE_EN to decode ROR and build the wrap path.
module shifter_pipe
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input logic      clk,
   input logic      rst,
   shifter_if.slave bus
);
   localparam int unsigned LW   = clog2(WIDTH);
   localparam int unsigned LAST = STAGES - 1;

   logic [STAGES-1:0] r_valid;
   logic [WIDTH-1:0]  r_data  [STAGES];
   logic [LW-1:0]     r_amt   [STAGES];
   logic [5:0]        r_funct [STAGES];
   logic [STAGES-1:0] r_ovf;
   logic [STAGES-1:0] r_sign;

   logic [WIDTH-1:0]  w_src_data  [STAGES];
   logic [LW-1:0]     w_src_amt   [STAGES];
   logic [5:0]        w_src_funct [STAGES];
   logic [STAGES-1:0] w_src_valid;
   logic [STAGES-1:0] w_src_ovf;
   logic [STAGES-1:0] w_src_sign;
   logic [STAGES-1:0] w_fill;
`ifdef SHIFTER_ROTATE_EN
   logic [STAGES-1:0] w_rot;
`endif
   logic [STAGES-1:0] w_load;

   logic [WIDTH-1:0]  w_lin  [LW];
   logic [WIDTH-1:0]  w_lout [LW];
   logic [WIDTH-1:0]  w_core [STAGES];
   logic [WIDTH-1:0]  w_nxt  [STAGES];

   logic [WIDTH-1:0]  w_rev_in;
   logic [WIDTH-1:0]  w_core_rev;
   logic [WIDTH-1:0]  w_post;
   logic [WIDTH-1:0]  w_result;

   assign w_rev_in   = {<<{bus.dataA}};
   assign w_core_rev = {<<{w_core[LAST]}};

   // Per-stage operand sources: stage 0 from the bus, later stages from the previous register.
   always_comb begin
      w_src_valid    = '0;
      w_src_ovf      = '0;
      w_src_sign     = '0;
      w_src_valid[0] = bus.in_valid;
      w_src_data[0]  = is_right(bus.Signal) ? w_rev_in : bus.dataA;
      w_src_amt[0]   = bus.dataB[LW-1:0];
      w_src_funct[0] = bus.Signal;
      w_src_ovf[0]   = (bus.dataB >= WIDTH'(WIDTH));
      w_src_sign[0]  = bus.dataA[WIDTH-1];
      for (int s = 1; s < int'(STAGES); s++) begin
         w_src_valid[s] = r_valid[s-1];
         w_src_data[s]  = r_data[s-1];
         w_src_amt[s]   = r_amt[s-1];
         w_src_funct[s] = r_funct[s-1];
         w_src_ovf[s]   = r_ovf[s-1];
         w_src_sign[s]  = r_sign[s-1];
      end
   end

   // Fill bit (sign for SRA) and rotate select per stage.
   always_comb begin
      w_fill = '0;
`ifdef SHIFTER_ROTATE_EN
      w_rot  = '0;
`endif
      for (int s = 0; s < int'(STAGES); s++) begin
         w_fill[s] = (w_src_funct[s] == FN_SRA) & w_src_sign[s];
`ifdef SHIFTER_ROTATE_EN
         w_rot[s]  = (w_src_funct[s] == FN_ROR);
`endif
      end
   end

   // Log levels, each wired to the stage that owns it.
   for (genvar k = 0; k < LW; k++) begin : g_lvl
      localparam int unsigned ST = stage_of_level(32'(k), STAGES, WIDTH);
      if (32'(k) == first_level(ST, STAGES, WIDTH)) begin : g_head
         assign w_lin[k] = w_src_data[ST];
      end else begin : g_chain
         assign w_lin[k] = w_lout[k-1];
      end
      shifter_level #(
         .WIDTH (WIDTH),
         .SHIFT (32'd1 << k)
      ) u_level (
         .i_data   (w_lin[k]),
         .i_en     (w_src_amt[ST][k]),
         .i_fill   (w_fill[ST]),
`ifdef SHIFTER_ROTATE_EN
         .i_rot    (w_rot[ST]),
`endif
         .o_data_c (w_lout[k])
      );
   end

   // Tap the last level output of each stage.
   for (genvar s = 0; s < STAGES; s++) begin : g_tap
      localparam int unsigned TAIL = first_level(32'(s), STAGES, WIDTH)
                                   + levels_in_stage(32'(s), STAGES, WIDTH) - 32'd1;
      assign w_core[s] = w_lout[TAIL];
   end

   // Final stage undoes the reversal and applies overflow / unknown-op results.
   always_comb begin
      w_post   = is_right(w_src_funct[LAST]) ? w_core_rev : w_core[LAST];
      w_result = '0;
      case (w_src_funct[LAST])
         FN_SLL, FN_SRL: w_result = w_src_ovf[LAST] ? '0 : w_post;
         FN_SRA:         w_result = w_src_ovf[LAST] ? {WIDTH{w_src_sign[LAST]}} : w_post;
`ifdef SHIFTER_ROTATE_EN
         FN_ROR:         w_result = w_post;
`endif
         default:        w_result = '0;
      endcase
   end

   // Next register data per stage.
   always_comb begin
      for (int s = 0; s < int'(STAGES); s++) w_nxt[s] = w_core[s];
      w_nxt[LAST] = w_result;
   end

   // Stage load enables: load when empty or when downstream accepts (bubbles collapse).
   always_comb begin
      logic w_dn;
      w_dn   = bus.out_ready;
      w_load = '0;
      for (int s = int'(LAST); s >= 0; s--) begin
         w_load[s] = ~r_valid[s] | w_dn;
         w_dn      = w_load[s];
      end
   end

   // Stage registers; payload only captured for valid beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_ovf   <= '0;
         r_sign  <= '0;
         for (int s = 0; s < int'(STAGES); s++) begin
            r_data[s]  <= '0;
            r_amt[s]   <= '0;
            r_funct[s] <= '0;
         end
      end else begin
         for (int s = 0; s < int'(STAGES); s++) begin
            if (w_load[s]) begin
               r_valid[s] <= w_src_valid[s];
               if (w_src_valid[s]) begin
                  r_data[s]  <= w_nxt[s];
                  r_amt[s]   <= w_src_amt[s];
                  r_funct[s] <= w_src_funct[s];
                  r_ovf[s]   <= w_src_ovf[s];
                  r_sign[s]  <= w_src_sign[s];
               end
            end
         end
      end
   end

   assign bus.in_ready  = w_load[0];
   assign bus.out_valid = r_valid[LAST];
   assign bus.dataOut   = r_data[LAST];

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe; ROR expectations follow SHIFTER_ROTATE_EN.
module tb_shifter_pipe;
   import shifter_pkg::*;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   int   n_done;
   logic sweep_go;

`ifdef SHIFTER_ROTATE_EN
   localparam logic ROT = 1'b1;
`else
   localparam logic ROT = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   shifter_if #(.WIDTH(32)) b32 ();
   shifter_pipe #(.WIDTH(32), .STAGES(2)) u_dut (.clk(clk), .rst(rst), .bus(b32));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference for the sweep instances.
   function automatic logic [63:0] ref_shift(input int unsigned w, input logic [5:0] fn,
                                             input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0] mask, a, b, r, sfill;
      int unsigned sh;
      logic        ovf, sgn;
      mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      a     = a_in & mask;
      b     = b_in & mask;
      ovf   = (b >= 64'(w));
      sh    = 32'(b % 64'(w));
      sgn   = a[w-1];
      sfill = sgn ? (mask & ~(mask >> sh)) : '0;
      case (fn)
         6'b000000: r = ovf ? '0 : ((a << sh) & mask);
         6'b000010: r = ovf ? '0 : (a >> sh);
         6'b000011: r = ovf ? (sgn ? mask : '0) : ((a >> sh) | sfill);
         6'b000110: r = ROT ? (((a >> sh) | (a << (w - sh))) & mask) : '0;
         default:   r = '0;
      endcase
      return r;
   endfunction

   function automatic int unsigned sw_width(input int g);
      return (g == 3) ? 32'd64 : 32'd32;
   endfunction

   function automatic int unsigned sw_stages(input int g);
      case (g)
         0:       return 32'd1;
         1:       return 32'd3;
         2:       return 32'd5;
         default: return 32'd4;
      endcase
   endfunction

   // Extra configurations checked against the reference model.
   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int unsigned W = sw_width(g);
      localparam int unsigned S = sw_stages(g);
      shifter_if #(.WIDTH(W)) bus ();
      shifter_pipe #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(rst), .bus(bus));

      initial begin
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         bus.dataA     = '0;
         bus.dataB     = '0;
         bus.Signal    = '0;
         wait (sweep_go);
         @(posedge clk);
         #1;
         for (int v = 0; v < 24; v++) begin
            logic [63:0] a, b, e;
            logic [5:0]  fn;
            int          n;
            case ($urandom_range(0, 4))
               0:       fn = FN_SLL;
               1:       fn = FN_SRL;
               2:       fn = FN_SRA;
               3:       fn = FN_ROR;
               default: fn = 6'b001010;
            endcase
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
               0, 1:    b = 64'($urandom_range(0, W - 1));
               2:       b = 64'($urandom_range(W, 2 * W));
               default: b = {$urandom, $urandom};
            endcase
            e = ref_shift(W, fn, a, b);
            bus.in_valid = 1'b1;
            bus.Signal   = fn;
            bus.dataA    = W'(a);
            bus.dataB    = W'(b);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            n = 1;
            while (!bus.out_valid && n < 20) begin
               @(posedge clk);
               #1;
               n++;
            end
            chk($sformatf("sw%0d_lat", g), 64'(n), 64'(S));
            chk($sformatf("sw%0d_dat", g), 64'(bus.dataOut), e);
            @(posedge clk);
            #1;
         end
         n_done++;
      end
   end

   // One beat through the 32/2 instance: ready, latency and result.
   task automatic run_one(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      int n;
      b32.in_valid  = 1'b1;
      b32.Signal    = fn;
      b32.dataA     = a;
      b32.dataB     = b;
      b32.out_ready = 1'b1;
      #1;
      chk({tag, "_rdy"}, 64'(b32.in_ready), 64'd1);
      step();
      b32.in_valid = 1'b0;
      n = 1;
      while (!b32.out_valid && n < 16) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'd2);
      chk({tag, "_dat"}, 64'(b32.dataOut), 64'(exp));
      step();
   endtask

   initial begin
      int          sent, got, occ, n;
      logic        stall_prev;
      logic [31:0] prev;
      n_vec         = 0;
      n_err         = 0;
      n_done        = 0;
      sweep_go      = 1'b0;
      rst           = 1'b1;
      b32.in_valid  = 1'b0;
      b32.out_ready = 1'b1;
      b32.dataA     = '0;
      b32.dataB     = '0;
      b32.Signal    = '0;
      repeat (3) step();
      chk("rst_valid", 64'(b32.out_valid), 64'd0);
      chk("rst_data", 64'(b32.dataOut), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_ready", 64'(b32.in_ready), 64'd1);

      run_one("sll31",   FN_SLL, 32'h0000_0001, 32'd31,         32'h8000_0000);
      run_one("sra4",    FN_SRA, 32'h8000_00F0, 32'd4,          32'hF800_000F);
      run_one("sra40",   FN_SRA, 32'h8000_00F0, 32'd40,         32'hFFFF_FFFF);
      run_one("srl40",   FN_SRL, 32'h8000_00F0, 32'd40,         32'h0000_0000);
      run_one("ror36",   FN_ROR, 32'h1234_5678, 32'd36,         ROT ? 32'h8123_4567 : 32'h0);
      run_one("sll0",    FN_SLL, 32'hA5A5_0F0F, 32'd0,          32'hA5A5_0F0F);
      run_one("srl31",   FN_SRL, 32'h8000_0000, 32'd31,         32'h0000_0001);
      run_one("sra_pos", FN_SRA, 32'h7000_0000, 32'd4,          32'h0700_0000);
      run_one("sll32",   FN_SLL, 32'hFFFF_FFFF, 32'd32,         32'h0000_0000);
      run_one("srl_big", FN_SRL, 32'hFFFF_FFFF, 32'h8000_0001,  32'h0000_0000);
      run_one("unknown", 6'b111111, 32'hFFFF_FFFF, 32'd3,       32'h0000_0000);
      run_one("sll5",    FN_SLL, 32'h0000_00FF, 32'd5,          32'h0000_1FE0);
      run_one("sra_ovp", FN_SRA, 32'h7FFF_FFFF, 32'd33,         32'h0000_0000);
      run_one("srl4",    FN_SRL, 32'h8000_00F0, 32'd4,          32'h0800_000F);
      run_one("ror0",    FN_ROR, 32'hDEAD_BEEF, 32'd0,          ROT ? 32'hDEAD_BEEF : 32'h0);
      run_one("ror1",    FN_ROR, 32'h0000_0001, 32'd1,          ROT ? 32'h8000_0000 : 32'h0);

      // Eight back-to-back beats with a three-cycle consumer stall.
      sent       = 0;
      got        = 0;
      occ        = 0;
      stall_prev = 1'b0;
      prev       = '0;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         b32.out_ready = !(cyc >= 4 && cyc < 7);
         b32.in_valid  = (sent < 8);
         b32.Signal    = FN_SLL;
         b32.dataA     = 32'h0000_0001;
         b32.dataB     = 32'(sent);
         #1;
         chk("b2b_rdy", 64'(b32.in_ready), 64'(!(occ == 2 && !b32.out_ready)));
         if (stall_prev) begin
            chk("b2b_hold_v", 64'(b32.out_valid), 64'd1);
            chk("b2b_hold_d", 64'(b32.dataOut), 64'(prev));
         end
         if (b32.out_valid && b32.out_ready) begin
            chk("b2b_data", 64'(b32.dataOut), 64'(32'd1 << got));
            got++;
            occ--;
         end
         if (b32.in_valid && b32.in_ready) begin
            sent++;
            occ++;
         end
         stall_prev = b32.out_valid & ~b32.out_ready;
         prev       = b32.dataOut;
         step();
      end
      chk("b2b_count", 64'(got), 64'd8);
      b32.in_valid  = 1'b0;
      b32.out_ready = 1'b1;

      // Reset with two beats in flight discards both.
      b32.out_ready = 1'b0;
      b32.in_valid  = 1'b1;
      b32.Signal    = FN_SLL;
      b32.dataA     = 32'h0000_0003;
      b32.dataB     = 32'd1;
      step();
      b32.dataB = 32'd2;
      step();
      b32.in_valid = 1'b0;
      chk("rst2_busy", 64'(b32.out_valid), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rst2_valid", 64'(b32.out_valid), 64'd0);
      chk("rst2_data", 64'(b32.dataOut), 64'd0);
      chk("rst2_ready", 64'(b32.in_ready), 64'd1);
      b32.out_ready = 1'b1;
      n = 0;
      repeat (6) begin
         if (b32.out_valid) n++;
         step();
      end
      chk("rst2_ghost", 64'(n), 64'd0);

      sweep_go = 1'b1;
      for (int i = 0; i < 3000 && n_done < 4; i++) step();
      chk("sweep_done", 64'(n_done), 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
